// File: rtl/la_capture.sv
// la_capture: pin logic analyser with mask/value trigger, sample divider,
// single-port capture RAM and a valid/ready packet drain.
// Ports: clk, rst (async, active-high);
//   packet_in/packet_in_valid: host config stream ([28] config, [23:20] op);
//   pin_vals: asynchronous pins under observation;
//   packet_out/packet_out_valid/packet_out_ready: sample + status stream;
//   busy: high whenever the engine is not IDLE.
module la_capture #(
  parameter int WIDTH = 32,
  parameter int PIN_W = 16,
  parameter int DEPTH = 64,
  parameter int DIV_W = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] packet_in,
  input  logic             packet_in_valid,
  input  logic [PIN_W-1:0] pin_vals,
  output logic [WIDTH-4:0] packet_out,
  output logic             packet_out_valid,
  input  logic             packet_out_ready,
  output logic             busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int OW = WIDTH - 3;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ARMED = 3'd1;
  localparam logic [2:0] S_CAPT  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]       state;
  logic [PIN_W-1:0] sync1;
  logic [PIN_W-1:0] sync2;
  logic             en_q;

  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] dcnt;
  logic [PIN_W-1:0] trig_mask;
  logic [PIN_W-1:0] trig_val;
  logic [CW-1:0]    count;
  logic [CW-1:0]    wptr;
  logic [CW-1:0]    rptr;

  logic [PIN_W-1:0] mem [DEPTH];
  logic [AW-1:0]    addr;
  logic [AW-1:0]    addr_q;
  logic [PIN_W-1:0] rdata;
  logic             rd_ok;

  logic [OW-1:0]    out_q;
  logic             out_v;

  logic [3:0]       op;
  logic [19:0]      pl;
  logic             cfg;
  logic             idle;
  logic             run;
  logic             tick;
  logic             hit;
  logic             abort;
  logic             do_arm;
  logic             we;
  logic             accept;
  logic             can_load;
  logic             drain_ld;
  logic             drain_end;
  logic [CW-1:0]    wptr_nx;
  logic [CW-1:0]    rptr_nx;
  logic [CW-1:0]    cnt_m1;
  logic [10:0]      arm_raw;
  logic [CW-1:0]    arm_cnt;
  logic [28:0]      data_pkt;
  logic [28:0]      stat_pkt;
  logic             unused_in;

  assign unused_in = ^packet_in;

  assign op   = packet_in[23:20];
  assign pl   = packet_in[19:0];
  // en_q holds off config decode for the first edge after reset release.
  assign cfg  = en_q & packet_in_valid & packet_in[28];
  assign idle = (state == S_IDLE);
  assign run  = (state == S_ARMED) | (state == S_CAPT);
  assign tick = run & (dcnt == div);
  assign hit  = ((sync2 ^ trig_val) & trig_mask) == '0;

  assign do_arm = cfg & idle & (op == 4'h4);
  assign abort  = cfg & (op == 4'h5) &
                  ((state == S_ARMED) |
                   (state == S_CAPT) |
                   (state == S_DRAIN));

  assign we = tick & ~abort &
              (((state == S_ARMED) & hit) |
               (state == S_CAPT));

  assign accept   = out_v & packet_out_ready;
  assign can_load = ~out_v | accept;

  assign wptr_nx = wptr + CW'(1);
  assign rptr_nx = rptr + CW'(1);
  assign cnt_m1  = count - CW'(1);

  // rptr is the index of the next sample to present. rdata always
  // shows mem[rptr] once rd_ok is set, because the address fed to the
  // RAM is the value rptr will hold after this edge.
  assign drain_ld  = (state == S_DRAIN) & ~abort & rd_ok &
                     can_load & (rptr != count);
  assign drain_end = (state == S_DRAIN) & ~abort &
                     can_load & (rptr == count);

  always_comb begin
    addr = rptr[AW-1:0];
    if (we) begin
      addr = wptr[AW-1:0];
    end else if (drain_ld) begin
      addr = rptr_nx[AW-1:0];
    end
  end

  assign arm_raw = {1'b0, pl[9:0]};

  always_comb begin
    arm_cnt = arm_raw[CW-1:0];
    if (arm_raw == 11'd0 || arm_raw > 11'(DEPTH)) begin
      arm_cnt = CW'(DEPTH);
    end
  end

  assign data_pkt = {1'b0, 2'b10, 2'b00, 8'h00, 16'(rdata)};
  assign stat_pkt = {1'b1, 2'b01, 2'b00, 8'h00, 6'h00,
                     10'(cnt_m1)};

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= sync2;
    end
    addr_q <= addr;
  end

  assign rdata = mem[addr_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q      <= 1'b0;
      sync1     <= '0;
      sync2     <= '0;
      div       <= '0;
      trig_mask <= '0;
      trig_val  <= '0;
      count     <= '0;
    end else begin
      en_q  <= 1'b1;
      sync1 <= pin_vals;
      sync2 <= sync1;
      if (cfg & idle) begin
        case (op)
          4'h1: div       <= pl[DIV_W-1:0];
          4'h2: trig_mask <= pl[PIN_W-1:0];
          4'h3: trig_val  <= pl[PIN_W-1:0];
          4'h4: count     <= arm_cnt;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dcnt <= '0;
    end else if (~run) begin
      dcnt <= '0;
    end else if (tick) begin
      dcnt <= '0;
    end else begin
      dcnt <= dcnt + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      wptr  <= '0;
      rptr  <= '0;
      rd_ok <= 1'b0;
      out_q <= '0;
      out_v <= 1'b0;
    end else begin
      rd_ok <= (state == S_DRAIN) & ~abort;
      unique case (state)
        S_IDLE: begin
          if (do_arm) begin
            state <= S_ARMED;
            wptr  <= '0;
            rptr  <= '0;
          end
        end
        S_ARMED: begin
          if (abort) begin
            state <= S_IDLE;
          end else if (we) begin
            wptr  <= CW'(1);
            state <= (count == CW'(1)) ? S_DRAIN : S_CAPT;
          end
        end
        S_CAPT: begin
          if (abort) begin
            state <= S_IDLE;
          end else if (we) begin
            wptr <= wptr_nx;
            if (wptr_nx == count) begin
              state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (abort) begin
            state <= S_IDLE;
            out_v <= 1'b0;
            out_q <= '0;
          end else if (drain_ld) begin
            out_q <= OW'(data_pkt);
            out_v <= 1'b1;
            rptr  <= rptr_nx;
          end else if (drain_end) begin
            out_q <= OW'(stat_pkt);
            out_v <= 1'b1;
            state <= S_DONE;
          end else if (accept) begin
            out_v <= 1'b0;
            out_q <= '0;
          end
        end
        S_DONE: begin
          if (accept) begin
            out_v <= 1'b0;
            out_q <= '0;
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
          out_v <= 1'b0;
        end
      endcase
    end
  end

  assign packet_out       = out_q;
  assign packet_out_valid = out_v;
  assign busy             = (state != S_IDLE);

endmodule

// File: tb/tb_la_capture.sv
// tb_la_capture: table-driven, directed and randomized checks of
// la_capture against a sample-schedule reference model.
module tb_la_capture;

  localparam int WIDTH = 32;
  localparam int PIN_W = 16;
  localparam int DEPTH = 64;
  localparam int DIV_W = 20;

  typedef logic [28:0] pkt_t;

  typedef struct {
    int pm;
    int dv;
    int mk;
    int vl;
    int cn;
    int nd;
    int st;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] packet_in = '0;
  logic        packet_in_valid = 1'b0;
  logic [15:0] pin_vals = '0;
  pkt_t        packet_out;
  logic        packet_out_valid;
  logic        packet_out_ready = 1'b1;
  logic        busy;

  la_capture #(
    .WIDTH(WIDTH),
    .PIN_W(PIN_W),
    .DEPTH(DEPTH),
    .DIV_W(DIV_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .packet_in(packet_in),
    .packet_in_valid(packet_in_valid),
    .pin_vals(pin_vals),
    .packet_out(packet_out),
    .packet_out_valid(packet_out_valid),
    .packet_out_ready(packet_out_ready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nmis = 0;
  int cyc = 0;
  int pin_mode = 0;
  int rdy_mode = 0;
  int t0 = 0;
  logic [15:0] pin_hold = '0;
  logic [15:0] plog [int];
  pkt_t got [$];
  pkt_t exp_q [$];
  vec_t tbl [7];

  always @(posedge clk) cyc <= cyc + 1;

  // Pins and ready change 1 time unit after each rising edge; every
  // pin value is logged against the edge count it follows.
  always @(posedge clk) begin
    #1;
    case (pin_mode)
      0: pin_vals = 16'(cyc);
      1: pin_vals = 16'($urandom);
      2: pin_vals = pin_hold;
      default: pin_vals = {cyc[14:0], (cyc >= t0)};
    endcase
    plog[cyc] = pin_vals;
    case (rdy_mode)
      0: packet_out_ready = 1'b1;
      1: packet_out_ready = ($urandom % 4) != 0;
      default: packet_out_ready = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    if (!rst && packet_out_valid && packet_out_ready)
      got.push_back(packet_out);
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] req);
    nvec++;
    if (act !== req) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic send(input logic flag, input logic [3:0] op,
                      input logic [19:0] pl, output int k);
    @(posedge clk);
    #1;
    packet_in = '0;
    packet_in[28] = flag;
    packet_in[23:20] = op;
    packet_in[19:0] = pl;
    packet_in_valid = 1'b1;
    k = cyc;
    @(posedge clk);
    #1;
    packet_in_valid = 1'b0;
  endtask

  task automatic setup(input int dv, input int mk, input int vl,
                       input int cn, output int k);
    int kk;
    send(1'b1, 4'h1, 20'(dv), kk);
    send(1'b1, 4'h2, 20'(mk), kk);
    send(1'b1, 4'h3, 20'(vl), kk);
    send(1'b1, 4'h4, 20'(cn), k);
  endtask

  // ARM issued after edge k takes effect at edge k+1; ticks then land
  // every div+1 edges, and the value seen at edge m is the pin value
  // driven after edge m-3 (two synchroniser stages).
  task automatic build_exp(input int dv, input int mk, input int vl,
                           input int cn, input int k);
    int n;
    int taken;
    int m;
    bit trig;
    logic [15:0] s;
    n = (cn == 0 || cn > DEPTH) ? DEPTH : cn;
    exp_q.delete();
    trig = 0;
    taken = 0;
    for (int j = 1; taken < n && j < 20000; j++) begin
      m = k + 1 + (dv + 1) * j;
      s = plog.exists(m - 3) ? plog[m - 3] : 16'h0;
      if (!trig && ((s ^ 16'(vl)) & 16'(mk)) == 16'h0) trig = 1;
      if (trig) begin
        exp_q.push_back({1'b0, 2'b10, 2'b00, 8'h00, s});
        taken++;
      end
    end
    exp_q.push_back({1'b1, 2'b01, 2'b00, 8'h00, 6'h00, 10'(n - 1)});
  endtask

  task automatic compare(input string name);
    check({name, " count"}, 64'(got.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      check($sformatf("%s pkt%0d", name, i), got[i], exp_q[i]);
  endtask

  task automatic wait_idle(input string name, input int bound);
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check({name, " idle"}, busy, 0);
  endtask

  initial begin
    int k;
    int d0;
    int d1;
    int dv;
    int mk;
    int vl;
    int cn;
    pkt_t held;

    tbl[0] = '{0, 0, 0, 0, 4, 4, 3};
    tbl[1] = '{0, 0, 0, 0, 1, 1, 0};
    tbl[2] = '{1, 1, 0, 0, 0, 64, 63};
    tbl[3] = '{0, 0, 0, 0, 64, 64, 63};
    tbl[4] = '{0, 2, 0, 0, 65, 64, 63};
    tbl[5] = '{1, 2, 0, 0, 1000, 64, 63};
    tbl[6] = '{1, 3, 3, 1, 5, 5, 4};

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset packet_out", packet_out, 0);
    check("reset valid", packet_out_valid, 0);
    check("reset busy", busy, 0);
    rst = 1'b0;
    repeat (3) @(posedge clk);

    foreach (tbl[i]) begin
      pin_mode = tbl[i].pm;
      got.delete();
      setup(tbl[i].dv, tbl[i].mk, tbl[i].vl, tbl[i].cn, k);
      wait_idle($sformatf("tbl%0d", i), 3000);
      build_exp(tbl[i].dv, tbl[i].mk, tbl[i].vl, tbl[i].cn, k);
      compare($sformatf("tbl%0d", i));
      check($sformatf("tbl%0d ndata", i),
            64'(got.size() - 1), 64'(tbl[i].nd));
      check($sformatf("tbl%0d status", i),
            got.size() > 0 ? 64'(got[got.size() - 1][9:0]) : 64'h3ff,
            64'(tbl[i].st));
    end

    // Triggered capture with div=9; a div write and an unflagged ABORT
    // arrive while armed and must both be ignored.
    got.delete();
    t0 = cyc + 100000;
    pin_mode = 3;
    setup(9, 1, 1, 2, k);
    t0 = k + 30;
    send(1'b1, 4'h1, 20'd0, d0);
    send(1'b0, 4'h5, 20'd0, d0);
    check("armed busy", busy, 1);
    wait_idle("trig", 1000);
    build_exp(9, 1, 1, 2, k);
    compare("trig");
    d0 = 0;
    d1 = 0;
    if (got.size() >= 2) begin
      d0 = int'(got[0][15:1]);
      d1 = int'(got[1][15:1]);
    end
    check("trig spacing", 64'(d1 - d0), 64'd10);

    // Full-depth drain with a ready stall.
    got.delete();
    pin_mode = 1;
    setup(0, 0, 0, 0, k);
    for (int i = 0; i < 500 && got.size() < 10; i++) @(negedge clk);
    rdy_mode = 2;
    @(negedge clk);
    held = packet_out;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall valid", packet_out_valid, 1);
      check("stall data", packet_out, held);
    end
    rdy_mode = 0;
    wait_idle("drain64", 1000);
    build_exp(0, 0, 0, 0, k);
    compare("drain64");

    // ABORT while armed.
    got.delete();
    pin_mode = 2;
    pin_hold = 16'h0000;
    setup(0, 1, 1, 4, k);
    repeat (5) @(posedge clk);
    send(1'b1, 4'h5, 20'd0, d0);
    check("abort armed busy", busy, 0);
    check("abort armed valid", packet_out_valid, 0);
    repeat (20) @(posedge clk);
    #1;
    check("abort armed pkts", 64'(got.size()), 0);

    // ABORT while capturing.
    pin_mode = 1;
    setup(3, 0, 0, 16, k);
    repeat (15) @(posedge clk);
    check("capt busy", busy, 1);
    send(1'b1, 4'h5, 20'd0, d0);
    check("abort capt busy", busy, 0);
    repeat (100) @(posedge clk);
    #1;
    check("abort capt pkts", 64'(got.size()), 0);

    // ABORT mid-drain with a packet waiting.
    rdy_mode = 2;
    setup(2, 1, 1, 4, k);
    for (int i = 0; i < 500 && !packet_out_valid; i++) @(negedge clk);
    check("drain pending valid", packet_out_valid, 1);
    send(1'b1, 4'h5, 20'd0, d0);
    check("abort drain busy", busy, 0);
    check("abort drain valid", packet_out_valid, 0);
    rdy_mode = 0;
    repeat (20) @(posedge clk);
    #1;
    check("abort drain pkts", 64'(got.size()), 0);

    // Fresh ARM reuses the retained div/mask/val.
    got.delete();
    send(1'b1, 4'h4, 20'd3, k);
    wait_idle("rearm", 1000);
    build_exp(2, 1, 1, 3, k);
    compare("rearm");

    // Reset in the middle of a capture.
    got.delete();
    pin_mode = 2;
    pin_hold = 16'hffff;
    setup(7, 3, 3, 8, k);
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("pre rst busy", busy, 1);
    rst = 1'b1;
    #1;
    check("rst packet_out", packet_out, 0);
    check("rst valid", packet_out_valid, 0);
    check("rst busy", busy, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    got.delete();
    pin_mode = 1;
    repeat (3) @(posedge clk);
    send(1'b1, 4'h4, 20'd2, k);
    wait_idle("post rst", 500);
    build_exp(0, 0, 0, 2, k);
    compare("post rst");

    // Randomized configurations with a random ready pattern.
    rdy_mode = 1;
    pin_mode = 1;
    for (int r = 0; r < 12; r++) begin
      dv = $urandom_range(0, 3);
      mk = $urandom_range(0, 3);
      vl = $urandom_range(0, 65535);
      cn = $urandom_range(1, 12);
      got.delete();
      setup(dv, mk, vl, cn, k);
      wait_idle($sformatf("rand%0d", r), 3000);
      build_exp(dv, mk, vl, cn, k);
      compare($sformatf("rand%0d", r));
    end
    rdy_mode = 0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
